// File: rtl/fifo_defs_pkg.sv
// Shared encodings for the register-file FIFO controllers.
// Read-side RD_* encodings are intended to join this package.
package fifo_defs_pkg;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'b00,
        WR_WRITE = 2'b01,
        WR_ERROR = 2'b10
    } wr_state_e;

endpackage

// File: rtl/fifo_row_decoder.sv
// Parametrised binary-to-one-hot row decoder with enable.
// Addresses at or beyond DEPTH decode to no row.
module fifo_row_decoder #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             i_en,
    input  logic [AW-1:0]    i_addr,
    output logic [DEPTH-1:0] o_row
);

    always_comb begin
        o_row = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_row[i] = i_en && (i_addr == AW'(i));
        end
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for the register-file FIFO: write pointer, occupancy, status.
// Optional sticky overflow flag with clear input under FIFO_WR_STICKY_ERR_EN.
module fifo_wr_ctrl
    import fifo_defs_pkg::*;
#(
    parameter  int unsigned DEPTH    = 8,
    parameter  int unsigned AFULL_TH = DEPTH - 1,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic             rd_pop,
    output logic [DEPTH-1:0] we_row,
    output logic [AW-1:0]    wr_ptr,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             almost_full,
    output logic             wr_ack,
    output logic             wr_err,
    output logic [1:0]       wr_state
`ifdef FIFO_WR_STICKY_ERR_EN
    ,
    input  logic             err_clr,
    output logic             ovf
`endif
);

    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_almost_full;
    logic          r_wr_ack;
    logic          r_wr_err;
    wr_state_e     r_state;

    logic          w_accept;
    logic          w_reject;
    logic          w_pop_ok;
    logic [AW-1:0] w_ptr_next;
    logic [CW-1:0] w_count_next;
    wr_state_e     w_state_next;

    // Gating with reset_n keeps the storage array quiet while reset is held.
    assign w_accept = wr_en & ~r_full & reset_n;
    assign w_reject = wr_en & r_full;
    assign w_pop_ok = rd_pop & (r_count != '0);

    fifo_row_decoder #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_row_decoder (
        .i_en   (w_accept),
        .i_addr (r_wr_ptr),
        .o_row  (we_row)
    );

    // Explicit wrap so non-power-of-two depths work.
    always_comb begin
        w_ptr_next = r_wr_ptr;
        if (w_accept) begin
            w_ptr_next = (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
        end
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_accept, w_pop_ok})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'(AFULL_TH == 0);
            r_wr_ack      <= 1'b0;
            r_wr_err      <= 1'b0;
        end else begin
            r_wr_ptr      <= w_ptr_next;
            r_count       <= w_count_next;
            r_full        <= (w_count_next == CW'(DEPTH));
            r_almost_full <= (w_count_next >= CW'(AFULL_TH));
            r_wr_ack      <= w_accept;
            r_wr_err      <= w_reject;
        end
    end

    // Operation-state FSM: state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= WR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state depends only on this cycle's request; unused 2'b11 falls back to idle.
    always_comb begin
        w_state_next = WR_IDLE;
        if (w_accept) begin
            w_state_next = WR_WRITE;
        end else if (w_reject) begin
            w_state_next = WR_ERROR;
        end
    end

`ifdef FIFO_WR_STICKY_ERR_EN
    logic r_ovf;

    // Set has priority over clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (w_reject) begin
            r_ovf <= 1'b1;
        end else if (err_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`endif

    assign wr_ptr      = r_wr_ptr;
    assign count       = r_count;
    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign wr_ack      = r_wr_ack;
    assign wr_err      = r_wr_err;
    assign wr_state    = r_state;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed self-checking bench for fifo_wr_ctrl (DEPTH=8 instance plus DEPTH=5 wrap instance).
// Covers the sticky overflow flag when FIFO_WR_STICKY_ERR_EN is defined.
module tb_fifo_wr_ctrl;

    logic       clk = 1'b0;
    logic       reset_n, wr_en, rd_pop;
    logic [7:0] we_row;
    logic [2:0] wr_ptr;
    logic [3:0] count;
    logic       full, almost_full, wr_ack, wr_err;
    logic [1:0] wr_state;
`ifdef FIFO_WR_STICKY_ERR_EN
    logic       err_clr, ovf;
    logic       b_err_clr, b_ovf;
`endif

    logic       b_reset_n, b_wr_en, b_rd_pop;
    logic [4:0] b_we_row;
    logic [2:0] b_wr_ptr;
    logic [2:0] b_count;
    logic       b_full, b_almost_full, b_wr_ack, b_wr_err;
    logic [1:0] b_wr_state;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_wr_ctrl #(.DEPTH(8)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .rd_pop      (rd_pop),
        .we_row      (we_row),
        .wr_ptr      (wr_ptr),
        .count       (count),
        .full        (full),
        .almost_full (almost_full),
        .wr_ack      (wr_ack),
        .wr_err      (wr_err),
        .wr_state    (wr_state)
`ifdef FIFO_WR_STICKY_ERR_EN
        ,
        .err_clr     (err_clr),
        .ovf         (ovf)
`endif
    );

    fifo_wr_ctrl #(.DEPTH(5)) u_dut5 (
        .clk         (clk),
        .reset_n     (b_reset_n),
        .wr_en       (b_wr_en),
        .rd_pop      (b_rd_pop),
        .we_row      (b_we_row),
        .wr_ptr      (b_wr_ptr),
        .count       (b_count),
        .full        (b_full),
        .almost_full (b_almost_full),
        .wr_ack      (b_wr_ack),
        .wr_err      (b_wr_err),
        .wr_state    (b_wr_state)
`ifdef FIFO_WR_STICKY_ERR_EN
        ,
        .err_clr     (b_err_clr),
        .ovf         (b_ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; wr_en = 1'b1; rd_pop = 1'b0;
        b_reset_n = 1'b0; b_wr_en = 1'b0; b_rd_pop = 1'b0;
`ifdef FIFO_WR_STICKY_ERR_EN
        err_clr = 1'b0; b_err_clr = 1'b0;
`endif
        #12;
        check("rst_we_row",  32'(we_row), 32'h0);
        check("rst_wr_ptr",  32'(wr_ptr), 32'd0);
        check("rst_count",   32'(count), 32'd0);
        check("rst_full",    32'(full), 32'd0);
        check("rst_afull",   32'(almost_full), 32'd0);
        check("rst_ack_err", 32'({wr_ack, wr_err}), 32'd0);
        check("rst_state",   32'(wr_state), 32'd0);

        tick();
        reset_n = 1'b1; wr_en = 1'b0;

        // Fill: row enable walks one-hot, status tracks occupancy.
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            #1;
            check($sformatf("fill_we_row%0d", i), 32'(we_row), 32'(1) << i);
            tick();
            check($sformatf("fill_ack%0d", i),   32'(wr_ack), 32'd1);
            check($sformatf("fill_err%0d", i),   32'(wr_err), 32'd0);
            check($sformatf("fill_count%0d", i), 32'(count), 32'(i + 1));
            check($sformatf("fill_ptr%0d", i),   32'(wr_ptr), 32'((i + 1) % 8));
            check($sformatf("fill_state%0d", i), 32'(wr_state), 32'd1);
            check($sformatf("fill_afull%0d", i), 32'(almost_full), (i + 1 >= 7) ? 32'd1 : 32'd0);
            check($sformatf("fill_full%0d", i),  32'(full), (i + 1 == 8) ? 32'd1 : 32'd0);
        end

        // Ninth write into a full FIFO is rejected.
        wr_en = 1'b1;
        #1;
        check("ovr_we_row", 32'(we_row), 32'h0);
        tick();
        check("ovr_err",   32'(wr_err), 32'd1);
        check("ovr_ack",   32'(wr_ack), 32'd0);
        check("ovr_state", 32'(wr_state), 32'd2);
        check("ovr_count", 32'(count), 32'd8);
        check("ovr_ptr",   32'(wr_ptr), 32'd0);
`ifdef FIFO_WR_STICKY_ERR_EN
        check("ovf_set", 32'(ovf), 32'd1);
`endif
        wr_en = 1'b0;
        tick();
        check("idle_err",   32'(wr_err), 32'd0);
        check("idle_state", 32'(wr_state), 32'd0);
`ifdef FIFO_WR_STICKY_ERR_EN
        check("ovf_hold", 32'(ovf), 32'd1);
        err_clr = 1'b1;
        tick();
        check("ovf_clr", 32'(ovf), 32'd0);
`endif

        // Full with write and pop together: write rejected, pop still counts.
        wr_en = 1'b1; rd_pop = 1'b1;
`ifdef FIFO_WR_STICKY_ERR_EN
        err_clr = 1'b1;
`endif
        #1;
        check("fp_we_row", 32'(we_row), 32'h0);
        tick();
        check("fp_err",   32'(wr_err), 32'd1);
        check("fp_count", 32'(count), 32'd7);
        check("fp_full",  32'(full), 32'd0);
        check("fp_state", 32'(wr_state), 32'd2);
`ifdef FIFO_WR_STICKY_ERR_EN
        check("ovf_set_wins", 32'(ovf), 32'd1);
        err_clr = 1'b0;
`endif
        rd_pop = 1'b0;
        #1;
        check("fp2_we_row", 32'(we_row), 32'h01);
        tick();
        check("fp2_ack",   32'(wr_ack), 32'd1);
        check("fp2_count", 32'(count), 32'd8);
        check("fp2_ptr",   32'(wr_ptr), 32'd1);
        check("fp2_full",  32'(full), 32'd1);

        // Drain, then pop while empty is ignored.
        wr_en = 1'b0; rd_pop = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("drain_count", 32'(count), 32'd0);
        check("drain_afull", 32'(almost_full), 32'd0);
        tick();
        check("empty_pop_count", 32'(count), 32'd0);
        check("empty_pop_err",   32'(wr_err), 32'd0);
        check("empty_pop_state", 32'(wr_state), 32'd0);

        rd_pop = 1'b0; wr_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("three_count", 32'(count), 32'd3);
        check("three_ptr",   32'(wr_ptr), 32'd4);
        rd_pop = 1'b1;
        #1;
        check("wp_we_row", 32'(we_row), 32'h10);
        tick();
        check("wp_count", 32'(count), 32'd3);
        check("wp_ptr",   32'(wr_ptr), 32'd5);
        check("wp_ack",   32'(wr_ack), 32'd1);

        // Asynchronous reset in the middle of a burst.
        rd_pop = 1'b0;
        tick();
        check("mid_count", 32'(count), 32'd4);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_ptr",   32'(wr_ptr), 32'd0);
        check("arst_flags", 32'({full, almost_full, wr_ack, wr_err}), 32'd0);
        check("arst_state", 32'(wr_state), 32'd0);
        check("arst_we_row", 32'(we_row), 32'h0);
`ifdef FIFO_WR_STICKY_ERR_EN
        check("arst_ovf", 32'(ovf), 32'd0);
`endif
        #2;
        reset_n = 1'b1;
        #1;
        check("post_rst_we_row", 32'(we_row), 32'h01);
        tick();
        check("post_rst_ptr",   32'(wr_ptr), 32'd1);
        check("post_rst_count", 32'(count), 32'd1);
        wr_en = 1'b0;

        // DEPTH=5 instance: pointer wraps by compare, not by overflow.
        b_reset_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            b_wr_en = 1'b1;
            #1;
            check($sformatf("d5_we_row%0d", i), 32'(b_we_row), 32'(1) << i);
            tick();
        end
        check("d5_ptr_wrap", 32'(b_wr_ptr), 32'd0);
        check("d5_full",     32'(b_full), 32'd1);
        check("d5_count",    32'(b_count), 32'd5);
        b_wr_en = 1'b0; b_rd_pop = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("d5_drain", 32'(b_count), 32'd0);
        b_rd_pop = 1'b0; b_wr_en = 1'b1;
        #1;
        check("d5_we_row6", 32'(b_we_row), 32'h01);
        tick();
        check("d5_ptr6", 32'(b_wr_ptr), 32'd1);
        #1;
        check("d5_we_row7", 32'(b_we_row), 32'h02);
        tick();
        check("d5_ptr7",   32'(b_wr_ptr), 32'd2);
        check("d5_count7", 32'(b_count), 32'd2);
        b_wr_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
- Parametrised write-side controller for the register-file FIFO.
- Holds the write pointer and occupancy count, and drives a DEPTH-wide one-hot row write-enable into the storage array.
- Reports full / almost-full status, a write acknowledge, a write error, and an operation state.
- Pop strobes from the read-side controller keep the occupancy count exact.

Parameters:
- DEPTH, 8: number of FIFO entries. Must be ≥2; need not be a power of two.
- AW, $clog2(DEPTH): pointer width, derived; not to be overridden.
- CW, $clog2(DEPTH+1): count width, derived.
- AFULL_TH, DEPTH-1: almost_full asserts when count ≥ AFULL_TH. Legal range 1..DEPTH.

Ports:
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous, active-low reset.
- wr_en, input, 1: write request, sampled each cycle.
- rd_pop, input, 1: entry removed by the read side this cycle.
- we_row, output, DEPTH: one-hot row write-enable to storage. Combinational.
- wr_ptr, output, AW: current write address. Registered.
- count, output, CW: occupancy. Registered.
- full, output, 1: count == DEPTH. Registered.
- almost_full, output, 1: count ≥ AFULL_TH. Registered.
- wr_ack, output, 1: previous-cycle write accepted. Registered.
- wr_err, output, 1: previous-cycle write rejected. Registered.
- wr_state, output, 2: last operation state. Registered.

Behaviour:
- Reset (reset_n low, asynchronous): wr_ptr=0, count=0, full=0, almost_full=0 (or 1 if AFULL_TH==0, which is illegal), wr_ack=0, wr_err=0, wr_state=IDLE. we_row=0 while in reset.
- Accept condition: accept = wr_en & ~full, using registered full. A pop in the same cycle does NOT let a write into a full FIFO.
- we_row = accept ? (1 << wr_ptr) : 0.
  - Combinational, same cycle as wr_en.
  - Storage captures on the same rising edge.
  - At most one bit is ever high.
- wr_ptr: increments on accept. Wraps from DEPTH-1 to 0 by explicit compare, not by natural overflow.
- Pop validity: pop_ok = rd_pop & (count != 0). A pop while empty is ignored with no underflow.
- Count update:
  - count_next = count + accept - pop_ok.
  - Simultaneous accept and pop_ok leaves count unchanged.
  - count never exceeds DEPTH.
- full and almost_full are computed from count_next and registered, so they are valid in the cycle after the update.
- wr_ack = accept and wr_err = wr_en & full, both registered. Each is a one-cycle pulse per request, never high together. Back-to-back requests give back-to-back pulses.
- wr_state FSM, one registered state updated every cycle:
  - IDLE (2'b00): wr_en=0 this cycle.
  - WRITE (2'b01): accept this cycle.
  - WR_ERROR (2'b10): wr_en & full this cycle.
  - 2'b11 is unused; if it is ever reached, return to IDLE.
  - Any state can move to any other state in a single cycle.
- Reset mid-burst: all state clears immediately. The first write after deassertion goes to row 0.

Optional Feature:
- Macro: FIFO_WR_STICKY_ERR_EN.
- When defined:
  - Adds input err_clr (1 bit) and output ovf (1 bit, registered).
  - ovf sets on any rejected write and holds until err_clr=1.
  - If set and clear occur in the same cycle, set wins.
  - Reset clears ovf.
- When undefined: neither port exists, and there is no extra logic.

Decomposition:
- Shared package/header fifo_defs:
  - State encodings WR_IDLE, WR_WRITE, WR_ERROR.
  - Shared later with the read-side controller's RD_* encodings.
- One sub-module: fifo_row_decoder, a parametrised N-to-one-hot decoder with enable (AW-bit input, DEPTH-bit output, en gate). It replaces the fixed 3-to-8 decoder and AND-gate array.
- Pointer, count, and FSM stay in fifo_wr_ctrl.

Test Plan:
- Reset, then 8 writes with DEPTH=8:
  - we_row walks 0x01, 0x02 … 0x80.
  - wr_ack pulses 8 cycles.
  - count reaches 8, full=1.
  - almost_full=1 from the cycle after count=7.
- Full plus a 9th write: we_row=0, wr_err=1 for one cycle, wr_state=WR_ERROR, count stays 8, wr_ptr=0.
- Full with wr_en=1 and rd_pop=1 together: write rejected (wr_err=1), count goes 8→7, full=0 next cycle. A following write is accepted at row 0.
- Empty with rd_pop=1: count stays 0, no error. Then wr_en=1 and rd_pop=1 with count=3: count stays 3, wr_ptr advances by 1.
- Wrap test with DEPTH=5 build: 5 writes, 5 pops, then 2 writes. we_row for the 6th and 7th writes is 0x01 and 0x02, with wr_ptr wrapping 4→0.
- reset_n pulsed low asynchronously mid-burst (count=4): all outputs are 0 without waiting for a clock edge. With FIFO_WR_STICKY_ERR_EN, ovf set by an overflow holds until err_clr, and reset clears it.
